// File: rtl/fetch_queue_pkg.sv
// Shared types for the fetch-to-decode instruction buffer.
// Holds the pipeline handshake structs and the queue entry layout.
package fetch_queue_pkg;

    localparam int FETCH_QUEUE_DEPTH = 4;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } FetchInfo;

    typedef struct packed {
        logic stall;
        logic flush;
    } PipeControl;

    typedef struct packed {
        logic       stall_req;
        logic [3:0] flush_req;
    } PipeRequest;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        err;
    } FetchQueueEntry;

endpackage

// File: rtl/fetch_queue.sv
// Circular FIFO buffering fetched instructions ahead of decode, with near-full stall request.
// Optional empty-queue bypass (zero latency) enabled by defining FETCH_QUEUE_BYPASS_EN.
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int DEPTH        = FETCH_QUEUE_DEPTH,
    parameter int STALL_MARGIN = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  PipeControl           pipe,
    input  logic                 in_valid,
    input  FetchInfo             in_info,
    input  logic                 in_error,
    output PipeRequest           req,
    output logic                 out_valid,
    output FetchInfo             out_info,
    output logic                 out_error,
    input  logic                 out_ready,
    output logic [$clog2(DEPTH):0] count,
    output logic                 overflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] THRESH_C = CNT_W'(DEPTH - STALL_MARGIN);

    FetchQueueEntry mem_q [DEPTH];

    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             overflow_q, overflow_d;
    logic             stall_req_q, stall_req_d;

    logic             head_valid;
    logic             bypass;
    logic             valid_out;
    logic             pop;
    logic             push;
    logic             do_push;
    logic             do_pop;
    FetchQueueEntry   in_entry;
    FetchQueueEntry   out_entry;

    always_comb begin
        in_entry   = '{pc: in_info.pc, inst: in_info.inst, err: in_error};
        head_valid = (count_q != '0);
`ifdef FETCH_QUEUE_BYPASS_EN
        bypass     = (count_q == '0) & in_valid & ~pipe.flush;
`else
        bypass     = 1'b0;
`endif
        valid_out  = head_valid | bypass;
        pop        = valid_out & out_ready & ~pipe.stall & ~pipe.flush;
        push       = in_valid & ~pipe.flush & ((count_q < DEPTH_C) | pop);
        // A bypassed entry consumed the same cycle never touches storage.
        do_push    = push & ~(bypass & pop);
        do_pop     = pop & ~bypass;
    end

    always_comb begin
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (pipe.flush) begin
            rd_ptr_d   = wr_ptr_q;
            count_d    = '0;
            overflow_d = 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            if (do_push && !do_pop) begin
                count_d = count_q + 1'b1;
            end else if (do_pop && !do_push) begin
                count_d = count_q - 1'b1;
            end
            if (in_valid && (count_q == DEPTH_C) && !pop) begin
                overflow_d = 1'b1;
            end
        end
        stall_req_d = (count_d >= THRESH_C);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            stall_req_q <= 1'b0;
        end else begin
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            stall_req_q <= stall_req_d;
        end
    end

    // Storage has no reset; the head is masked to zero while empty instead.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= in_entry;
        end
    end

    always_comb begin
        if (bypass) begin
            out_entry = in_entry;
        end else if (head_valid) begin
            out_entry = mem_q[rd_ptr_q];
        end else begin
            out_entry = '0;
        end
    end

    assign out_valid     = valid_out;
    assign out_info.pc   = out_entry.pc;
    assign out_info.inst = out_entry.inst;
    assign out_error     = out_entry.err;
    assign count         = count_q;
    assign overflow      = overflow_q;
    assign req.stall_req = stall_req_q;
    assign req.flush_req = 4'b0000;

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Instruction buffer between the fetch stage and decode; consumes the fetch stage's FetchInfo {pc, inst} plus its icache error bit.
- Decouples fetch from decode back-pressure: a DEPTH-entry circular FIFO with valid/ready toward decode.
- Raises a stall request toward the pipeline controller before it can overflow.
- Flushed by the IF/ID PipeControl on redirects.

Parameters:
- DEPTH, 4, number of entries; power of 2, >= 2.
- STALL_MARGIN, 1, free slots kept in reserve when stall_req is raised; covers the one-cycle fetch response lag.

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- pipe  input  PipeControl  IF/ID control; .stall freezes pop, .flush empties the queue
- in_valid  input  1  fetch presents a FetchInfo this cycle
- in_info  input  FetchInfo  {pc, inst} from fetch
- in_error  input  1  icache error accompanying in_info
- req  output  PipeRequest  .stall_req = near-full; .flush_req = 4'b0000 always
- out_valid  output  1  head entry valid toward decode
- out_info  output  FetchInfo  head entry {pc, inst}
- out_error  output  1  head entry icache error bit
- out_ready  input  1  decode accepts the head this cycle
- count  output  $clog2(DEPTH)+1  current occupancy
- overflow  output  1  sticky: a valid push was dropped

Behaviour:
- Reset (rst_n low, asynchronous): rd_ptr = 0, wr_ptr = 0, count = 0, overflow = 0; storage is not cleared. All outputs read 0: out_valid, out_info, out_error, req.stall_req.
- Storage: DEPTH entries of {pc[31:0], inst[31:0], err}. Pointers are $clog2(DEPTH) bits and wrap naturally at DEPTH-1 -> 0.
- pop = out_valid & out_ready & !pipe.stall & !pipe.flush.
- push = in_valid & !pipe.flush & (count < DEPTH | pop). A push is therefore allowed on a full queue when a pop occurs in the same cycle.
- Occupancy: count += push - pop. Simultaneous push and pop leaves count unchanged and advances both pointers.
- Latency: a pushed entry is visible at out_* the next cycle (1 cycle).
- Head output: out_valid = (count != 0). out_info and out_error are driven combinationally from the entry at rd_ptr. They hold stable while out_valid & !out_ready.
- pipe.flush:
  - Next cycle: count = 0 and rd_ptr = wr_ptr. Pointers are not reset to 0.
  - Any push or pop in the flush cycle is discarded.
  - Flush takes priority over stall.
  - Flush also clears overflow.
- pipe.stall: blocks pop only; pushes are still accepted.
- req.stall_req: registered. Asserted the cycle after count_next >= DEPTH - STALL_MARGIN. Deasserted likewise when count_next falls below the threshold.
- Overflow: set when in_valid & !pipe.flush & count == DEPTH & !pop. The dropped entry is discarded. overflow is sticky until flush or reset.
- Full/empty boundaries:
  - pop never occurs when empty (out_valid = 0).
  - count never exceeds DEPTH.

Optional Feature:
- Macro: FETCH_QUEUE_BYPASS_EN.
- Defined:
  - When count == 0 & in_valid & !pipe.flush, out_valid = 1 and out_* are driven combinationally from in_*.
  - If pop occurs that cycle, the entry is not written; pointers and count are unchanged.
  - Otherwise it is pushed normally.
  - Latency is 0 when empty.
- Undefined: no combinational in -> out path; latency is always 1 cycle.

Decomposition:
- Shared common package:
  - FetchQueueEntry typedef {logic [31:0] pc; logic [31:0] inst; logic err;}.
  - FETCH_QUEUE_DEPTH default constant.
- Reuse the package's existing FetchInfo, PipeControl and PipeRequest.
- No sub-module: pointers, counter and storage array stay inline; the block is small and single-purpose.

Test Plan:
- Reset and fill: reset, then 4 consecutive pushes pc = 0x0, 0x4, 0x8, 0xC with out_ready = 0 -> count = 4, out_info.pc = 0x0, stall_req high from cycle 4 (count_next >= 3), overflow = 0.
- Overflow: full queue, 5th push pc = 0x10 with out_ready = 0 -> overflow = 1, count = 4, head still pc = 0x0.
- Steady state: out_ready = 1, continuous pushes pc = 0x0.. -> count stays 1, each output pc is the input pc one cycle earlier, 10 pushes with wrap-around and no loss or duplication.
- Flush: count = 3, assert pipe.flush with in_valid and out_ready = 1 -> next cycle count = 0, out_valid = 0, overflow = 0, flush-cycle input not stored.
- Stall: count = 2, pipe.stall = 1, out_ready = 1, one push -> count = 3, head unchanged; release stall -> pops resume in order.
- Bypass (FETCH_QUEUE_BYPASS_EN defined, empty queue): in_valid with pc = 0x40 and out_ready = 1 -> out_valid = 1 and out_info.pc = 0x40 the same cycle, count stays 0. Macro undefined -> appears one cycle later.
